// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port and decode valid/ready port.
// master = fetch unit, slave = memory + decode side.
interface instr_fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_ack, i_imem_rdata,
        output o_valid, o_instr, o_pc,
        input  i_ready
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_ack, i_imem_rdata,
        input  o_valid, o_instr, o_pc,
        output i_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, imem req/ack, small instr/pc FIFO toward decode, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: flag misaligned redirect targets and stall fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    instr_fetch_unit_if.master    bus,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_misaligned
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [AW+1:0] ONE_W   = (AW+2)'(1);
    localparam logic [AW:0]   ONE_P   = (AW+1)'(1);

    typedef enum logic [1:0] {FETCH, IDLE, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;
    logic [AW:0]   wptr_q, rptr_q;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   ipc_q   [DEPTH];

    logic          req, ack, push, pop, flush, valid;
    logic [AW+1:0] cnt, cnt_pop;
    logic [31:0]   rpc;
    logic          mis_redir, mis_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign rpc       = i_redirect_pc;
    assign mis_redir = |i_redirect_pc[1:0];

    // Misalignment flag: set/cleared by each redirect, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst)           mis_q <= 1'b0;
        else if (i_redirect) mis_q <= mis_redir;
    end

    assign o_misaligned = mis_q;
`else
    assign rpc          = i_redirect_pc & 32'hFFFF_FFFC;
    assign mis_redir    = 1'b0;
    assign mis_q        = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    assign cnt     = {1'b0, wptr_q - rptr_q};
    assign valid   = (cnt != '0);
    assign pop     = valid && bus.i_ready && !i_redirect;
    assign cnt_pop = cnt - {{(AW+1){1'b0}}, pop};

    // Next state: request/ack handling, redirect flush, drop of abandoned response
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        flush       = 1'b0;
        req         = ((state_q == FETCH) || (state_q == DROP)) && !i_rst;
        ack         = req && bus.i_imem_ack;
        unique case (state_q)
            FETCH: begin
                if (i_redirect) begin
                    flush = 1'b1;
                    pc_d  = rpc;
                    if (ack) begin
                        state_d = mis_redir ? IDLE : FETCH;
                    end else begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = (cnt_pop + ONE_W < DEPTH_W) ? FETCH : IDLE;
                end
            end
            IDLE: begin
                if (i_redirect) begin
                    flush   = 1'b1;
                    pc_d    = rpc;
                    state_d = mis_redir ? IDLE : FETCH;
                end else if (!mis_q && (cnt_pop < DEPTH_W)) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (i_redirect) begin
                    flush = 1'b1;
                    pc_d  = rpc;
                end
                if (ack) begin
                    state_d = (i_redirect ? mis_redir : mis_q) ? IDLE : FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State, PC and FIFO pointer registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + ONE_P;
                if (pop)  rptr_q <= rptr_q + ONE_P;
            end
        end
    end

    // FIFO storage write (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_q[wptr_q[AW-1:0]] <= bus.i_imem_rdata;
            ipc_q[wptr_q[AW-1:0]]   <= pc_q;
        end
    end

    assign bus.o_imem_req  = req;
    assign bus.o_imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign bus.o_valid     = valid;
    assign bus.o_instr     = instr_q[rptr_q[AW-1:0]];
    assign bus.o_pc        = ipc_q[rptr_q[AW-1:0]];
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that produces the instruction stream consumed by the decode stage's control unit. Keeps the fetch PC, requests 32-bit instruction words from instruction memory over a req/ack handshake, buffers returned words with their PCs in a small FIFO, and presents them to decode over a valid/ready interface. Branch/jump redirects flush the buffer and restart fetch at the target PC, including correct discard of an in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 2, FIFO entries; power of two, >= 2
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- o_imem_req  output  1  fetch request; level, held until ack
- o_imem_addr  output  32  fetch address; stable while o_imem_req high
- i_imem_ack  input  1  request completed; i_imem_rdata valid this cycle
- i_imem_rdata  input  32  instruction word
- o_valid  output  1  FIFO head valid toward decode
- o_instr  output  32  head instruction
- o_pc  output  32  head PC
- i_ready  input  1  decode accepts head this cycle
- i_redirect  input  1  one-cycle redirect pulse from branch/jump resolution
- i_redirect_pc  input  32  redirect target
- o_misaligned  output  1  misaligned redirect target flag (FETCH_MISALIGN_CHECK_EN only; else tied 0)

## Operation
- Registers: fetch PC, FIFO (instr+pc per entry), read/write pointers with one extra wrap bit, FSM state.
- FSM states: FETCH (o_imem_req=1, addr=fetch PC), IDLE (no request), DROP (o_imem_req=1 on the old address, response to be discarded).
- Space rule: a request may be raised only if FIFO count + (1 if request outstanding) < DEPTH; evaluated on registered count, so request never overflows FIFO.
- FETCH: on i_imem_ack, push {i_imem_rdata, fetch PC}, fetch PC += 4 (32-bit wrap); stay FETCH if space remains after push and pop of this cycle, else IDLE. No ack: hold address.
- IDLE: go FETCH when space available.
- Decode side: o_valid = FIFO not empty; pop when o_valid && i_ready. Push and pop in same cycle allowed, also at full (pop frees slot the push uses).
- Redirect (priority over push and pop): FIFO emptied (o_valid=0 next cycle), fetch PC <= i_redirect_pc. If request pending and not acked this cycle -> DROP (protocol forbids abandoning a request). If acked this cycle or no request pending -> data discarded, FETCH next cycle.
- DROP: hold old address until ack; discard data; then FETCH at redirect PC. Second redirect while in DROP: update fetch PC only, stay DROP.
- Pop ignored during the redirect cycle.

## Timing
- Reset: fetch PC=RESET_PC, FIFO empty, o_valid=0, o_imem_req=0, o_misaligned=0, state FETCH-pending; first o_imem_req=1 in cycle after i_rst deasserts.
- Ack may arrive in the same cycle as req rises (combinational memory) -> throughput 1 instr/cycle with i_ready held high.
- Fill latency: ack in cycle N -> o_valid=1, o_instr/o_pc valid in cycle N+1.
- Redirect in cycle N -> o_imem_addr=i_redirect_pc in N+1 (no pending request) or in cycle after the discarded ack.
- o_instr/o_pc stable while o_valid && !i_ready.
- Reset mid-operation: pending request dropped immediately; memory must tolerate req deassertion on reset.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect target with pc[1:0]!=0 sets o_misaligned (registered, high from next cycle) and FSM to IDLE with no requests until next aligned redirect or reset; in-flight response still discarded via DROP.
- Not defined: o_misaligned tied 0; i_redirect_pc[1:0] forced to 2'b00.

## Test plan
- Reset, zero-wait memory, i_ready=1 -> o_pc 0x0,0x4,0x8,... one per cycle from 2nd cycle after reset; instr matches memory.
- i_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 acks then o_imem_req=0; release -> words at 0x0,0x4,0x8 in order, none lost or duplicated.
- Memory 3-cycle ack latency, redirect to 0x100 at cycle 1 of wait -> old address held until ack, its data never on o_instr, next o_imem_addr=0x100, first o_pc=0x100.
- Redirect to 0x200 in same cycle as ack and full FIFO pop -> o_valid=0 next cycle, next o_pc=0x200.
- Fetch PC 0xFFFF_FFFC -> next fetch address 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> o_misaligned=1, no requests; redirect to 0x104 -> o_misaligned=0, fetch resumes at 0x104.
